// File: rtl/divisor_arbitro.sv
// divisor_arbitro: round-robin arbiter sharing one START/DONE divider among N_REQ clients
//   clk, rst             clock and asynchronous active-high reset
//   req, num_in, den_in  per-client request and packed operands (client i at [i*SIZE +: SIZE])
//   ack, res_valid       one-cycle accept / result pulses to the granted client
//   coc_out, res_out     quotient / remainder, valid with res_valid
//   err_out              {timeout, div_by_zero}, valid with res_valid
//   busy                 high whenever not idle
//   div_start/num/den    command side of the shared divider
//   div_coc/res/done     result side of the shared divider
module divisor_arbitro #(
   parameter int SIZE    = 8,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*SIZE-1:0]   num_in,
   input  logic [N_REQ*SIZE-1:0]   den_in,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        res_valid,
   output logic [SIZE-1:0]         coc_out,
   output logic [SIZE-1:0]         res_out,
   output logic [1:0]              err_out,
   output logic                    busy,
   output logic                    div_start,
   output logic [SIZE-1:0]         div_num,
   output logic [SIZE-1:0]         div_den,
   input  logic [SIZE-1:0]         div_coc,
   input  logic [SIZE-1:0]         div_res,
   input  logic                    div_done
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3;
   logic [1:0]      state_q;
   logic [GW-1:0]   last_q, grant_d;
   logic            found_d;
   logic [GW:0]     idx;
   logic [CW-1:0]   cnt_q;
   logic [SIZE-1:0] coc_q, res_q, g_num, g_den;
   logic [1:0]      err_q;
   assign busy  = state_q != IDLE;
   assign g_num = num_in[grant_d*SIZE +: SIZE];
   assign g_den = den_in[grant_d*SIZE +: SIZE];
   // Scan downward so the last hit is the first requester after last_q (wrapping).
   always_comb begin
      grant_d = last_q;
      found_d = 1'b0;
      idx     = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = {1'b0, last_q} + (GW+1)'(i);
         if (idx >= (GW+1)'(N_REQ)) idx = idx - (GW+1)'(N_REQ);
         if (req[idx[GW-1:0]]) begin
            grant_d = idx[GW-1:0];
            found_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= GW'(N_REQ - 1);
         cnt_q     <= '0;
         coc_q     <= '0;
         res_q     <= '0;
         err_q     <= '0;
         ack       <= '0;
         res_valid <= '0;
         coc_out   <= '0;
         res_out   <= '0;
         err_out   <= '0;
         div_start <= 1'b0;
         div_num   <= '0;
         div_den   <= '0;
      end else begin
         ack       <= '0;
         res_valid <= '0;
         coc_out   <= '0;
         res_out   <= '0;
         err_out   <= '0;
         div_start <= 1'b0;
         case (state_q)
            IDLE: if (found_d) begin
               ack     <= N_REQ'(1) << grant_d;
               last_q  <= grant_d;
               div_num <= g_num;
               div_den <= g_den;
               // Zero divisor never reaches the divider; answer is prepared here.
               coc_q   <= '1;
               res_q   <= g_num;
               err_q   <= 2'b01;
               state_q <= (g_den == '0) ? RESP : START;
            end
            START: begin
               div_start <= 1'b1;
               cnt_q     <= '0;
               state_q   <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // Done has priority over a coincident timeout.
               if (div_done) begin
                  coc_q   <= div_coc;
                  res_q   <= div_res;
                  err_q   <= 2'b00;
                  state_q <= RESP;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  coc_q   <= '0;
                  res_q   <= '0;
                  err_q   <= 2'b10;
                  state_q <= RESP;
               end
            end
            default: begin
               res_valid <= N_REQ'(1) << last_q;
               coc_out   <= coc_q;
               res_out   <= res_q;
               err_out   <= err_q;
               state_q   <= IDLE;
            end
         endcase
      end
   end
endmodule
